// File: rtl/cpu_dump_pkg.sv
// Shared types and constants for the CPU state dumper.
// The header length depends on the DUMP_PERF_CNT_EN build macro: with it the
// header carries PC plus the cycle/stall/flush counters, without it PC only.
package cpu_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG,
        ST_MEM
    } state_e;

    localparam int IDX_W             = 6;
    localparam int DEF_NUM_REGS      = 32;
    localparam int DEF_NUM_MEM_WORDS = 8;

`ifdef DUMP_PERF_CNT_EN
    localparam int HDR_LEN = 4;
`else
    localparam int HDR_LEN = 1;
`endif

    localparam int TOTAL_WORDS = HDR_LEN + DEF_NUM_REGS + DEF_NUM_MEM_WORDS;

    // Stream region that a given word index belongs to.
    function automatic state_e region_of(input int idx, input int num_regs);
        if (idx < HDR_LEN) begin
            return ST_HDR;
        end else if (idx < HDR_LEN + num_regs) begin
            return ST_REG;
        end else begin
            return ST_MEM;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances by one when inc_i is high and holds at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    output logic [DATA_W-1:0] cnt_o
);

    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;

    // Next count: increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {DATA_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams CPU architectural state (header, register file, data memory) over a
// valid/ready port. Build macro DUMP_PERF_CNT_EN adds saturating cycle/stall/
// flush counters and places them in the header after the PC.
//
// Handshake: a word transfers on a rising edge where dump_valid_o and
// dump_ready_i are both high; while valid is high and ready is low, data, idx
// and last hold their values. The output register reloads whenever it is empty
// or its word is being accepted.
module cpu_state_dumper
    import cpu_dump_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic              dump_req_i,
    output logic              busy_o,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [IDX_W-1:0]  dump_idx_o,
    output logic              dump_last_o
);

    localparam int               TOTAL     = HDR_LEN + NUM_REGS + NUM_MEM_WORDS;
    localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0] REG_BASE  = IDX_W'(HDR_LEN);
    localparam logic [IDX_W-1:0] MEM_BASE  = IDX_W'(HDR_LEN + NUM_REGS);

    state_e              state_q;
    logic                busy_q;
    logic                valid_q;
    logic                last_q;
    logic [DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    ld_idx_q;   // index of the next word to load
    logic [DATA_W-1:0]   ld_word_d;  // value of that word

`ifdef DUMP_PERF_CNT_EN
    logic [DATA_W-1:0] cyc_cnt;
    logic [DATA_W-1:0] stall_cnt;
    logic [DATA_W-1:0] flush_cnt;
    logic [DATA_W-1:0] hdr_cyc_q;
    logic [DATA_W-1:0] hdr_stall_q;
    logic [DATA_W-1:0] hdr_flush_q;

    // A stall during a branch decode is the branch's own bubble, not a hazard.
    sat_counter #(.DATA_W(DATA_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (start_i),
        .cnt_o (cyc_cnt)
    );

    sat_counter #(.DATA_W(DATA_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (start_i && stall_i && !branch_i),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.DATA_W(DATA_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (start_i && flush_i),
        .cnt_o (flush_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = ^{start_i, stall_i, branch_i, flush_i};
`endif

    // Select the next word and drive read addresses for it (reads are live).
    always_comb begin
        ld_word_d  = '0;
        reg_addr_o = '0;
        mem_addr_o = '0;
        case (state_q)
            ST_HDR: begin
`ifdef DUMP_PERF_CNT_EN
                case (ld_idx_q)
                    IDX_W'(1): ld_word_d = hdr_cyc_q;
                    IDX_W'(2): ld_word_d = hdr_stall_q;
                    default:   ld_word_d = hdr_flush_q;
                endcase
`else
                ld_word_d = '0;
`endif
            end
            ST_REG: begin
                reg_addr_o = 5'(ld_idx_q - REG_BASE);
                ld_word_d  = reg_data_i;
            end
            ST_MEM: begin
                if (ld_idx_q < TOTAL_IDX) begin
                    mem_addr_o = DATA_W'(ld_idx_q - MEM_BASE) << 2;
                    ld_word_d  = mem_data_i;
                end
            end
            default: ld_word_d = '0;
        endcase
    end

    // Dump FSM and output register: PC goes out straight from the request,
    // later words load as each is accepted; the last handshake returns to idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            ld_idx_q <= '0;
`ifdef DUMP_PERF_CNT_EN
            hdr_cyc_q   <= '0;
            hdr_stall_q <= '0;
            hdr_flush_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dump_req_i) begin
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        data_q   <= pc_i;
                        idx_q    <= '0;
                        last_q   <= (LAST_IDX == '0);
                        ld_idx_q <= IDX_W'(1);
                        state_q  <= region_of(1, NUM_REGS);
`ifdef DUMP_PERF_CNT_EN
                        hdr_cyc_q   <= cyc_cnt;
                        hdr_stall_q <= stall_cnt;
                        hdr_flush_q <= flush_cnt;
`endif
                    end
                end
                default: begin
                    if (valid_q && dump_ready_i && last_q) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!valid_q || dump_ready_i) begin
                        valid_q  <= 1'b1;
                        data_q   <= ld_word_d;
                        idx_q    <= ld_idx_q;
                        last_q   <= (ld_idx_q == LAST_IDX);
                        ld_idx_q <= ld_idx_q + 1'b1;
                        state_q  <= region_of(int'(ld_idx_q) + 1, NUM_REGS);
                    end
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign dump_valid_o = valid_q;
    assign dump_data_o  = data_q;
    assign dump_idx_o   = idx_q;
    assign dump_last_o  = last_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Testbench for cpu_state_dumper. Plays the CPU side (register file and data
// memory arrays, PC and strobes) and the stream sink. A reference model built
// from the stream definition predicts every word; header counter checks run
// only when DUMP_PERF_CNT_EN is defined.
module tb_cpu_state_dumper;

`ifdef DUMP_PERF_CNT_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 1;
`endif
    localparam int TOTAL = HDR + 32 + 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        dump_req_i = 1'b0;
    logic        busy_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b1;
    logic [31:0] dump_data_o;
    logic [5:0]  dump_idx_o;
    logic        dump_last_o;

    always #5 clk = ~clk;

    cpu_state_dumper dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .flush_i      (flush_i),
        .dump_req_i   (dump_req_i),
        .busy_o       (busy_o),
        .reg_addr_o   (reg_addr_o),
        .reg_data_i   (reg_data_i),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_data_o  (dump_data_o),
        .dump_idx_o   (dump_idx_o),
        .dump_last_o  (dump_last_o)
    );

    // CPU-side storage, read combinationally like the real arrays.
    logic [31:0] regs [32];
    logic [31:0] mem  [8];
    always_comb reg_data_i = regs[reg_addr_o];
    always_comb mem_data_i = mem[mem_addr_o[4:2]];

    // ---------------- scoreboard / model state ----------------
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    bit          m_busy = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    int          n_streams = 0;
    int          n_holds = 0;
    logic [31:0] got [64];
    int          got_last_idx = -1;
    int          ready_mode = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [5:0]  prev_idx;
    logic        prev_last;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare process: samples just after each negedge (inputs already
    // settled), checks the outputs, then advances the model for the next edge.
    always @(negedge clk) begin
        #1;
        if (rst_i) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_idx = 0;
            m_cyc = '0;
            m_stall = '0;
            m_flush = '0;
            prev_hold = 1'b0;
            check32("rst_valid", 32'(dump_valid_o), 32'd0);
            check32("rst_busy", 32'(busy_o), 32'd0);
        end else begin
            check32("busy", 32'(busy_o), 32'(m_busy));
            check32("valid", 32'(dump_valid_o), 32'(m_busy));
            if (m_busy && dump_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL data: got 0x%08h expected no word", dump_data_o);
                end else begin
                    check32("data", dump_data_o, exp_q[0]);
                end
                check32("idx", 32'(dump_idx_o), 32'(m_idx));
                check32("last", 32'(dump_last_o), 32'(m_idx == TOTAL - 1));
                if (prev_hold) begin
                    n_holds++;
                    check32("hold_data", dump_data_o, prev_data);
                    check32("hold_idx", 32'(dump_idx_o), 32'(prev_idx));
                    check32("hold_last", 32'(dump_last_o), 32'(prev_last));
                end
                got[dump_idx_o] = dump_data_o;
                if (dump_last_o) got_last_idx = int'(dump_idx_o);
            end
            prev_hold = dump_valid_o && !dump_ready_i;
            prev_data = dump_data_o;
            prev_idx  = dump_idx_o;
            prev_last = dump_last_o;

            if (m_busy && dump_valid_o && dump_ready_i) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (m_idx == TOTAL - 1) begin
                    m_busy = 1'b0;
                    n_streams++;
                end
                m_idx++;
            end else if (!m_busy && dump_req_i) begin
                exp_q.delete();
                exp_q.push_back(pc_i);
`ifdef DUMP_PERF_CNT_EN
                exp_q.push_back(m_cyc);
                exp_q.push_back(m_stall);
                exp_q.push_back(m_flush);
`endif
                for (int i = 0; i < 32; i++) exp_q.push_back(regs[i]);
                for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
                m_busy = 1'b1;
                m_idx = 0;
            end

            if (start_i) begin
                if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
                if (stall_i && !branch_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                if (flush_i && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic req, input logic st = 1'b0, input logic stl = 1'b0,
                        input logic br = 1'b0, input logic fl = 1'b0);
        @(negedge clk);
        dump_req_i = req;
        start_i    = st;
        stall_i    = stl;
        branch_i   = br;
        flush_i    = fl;
        case (ready_mode)
            0:       dump_ready_i = 1'b1;
            1:       dump_ready_i = ~dump_ready_i;
            default: dump_ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic finish_dump(input string name);
        for (int k = 0; k < 500; k++) begin
            tick(1'b0);
            #2;
            if (!busy_o) break;
        end
        check32({name, "_done"}, 32'(busy_o), 32'd0);
    endtask

    task automatic randomize_cpu();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        for (int i = 0; i < 64; i++) got[i] = 32'hDEAD_BEEF;
        got_last_idx = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int streams_before;
        randomize_cpu();

        // 1: reset values, then a basic dump with fixed markers.
        repeat (3) @(negedge clk);
        #2;
        check32("reset_busy", 32'(busy_o), 32'd0);
        check32("reset_valid", 32'(dump_valid_o), 32'd0);
        check32("reset_last", 32'(dump_last_o), 32'd0);
        check32("reset_data", dump_data_o, 32'd0);
        check32("reset_idx", 32'(dump_idx_o), 32'd0);
        check32("reset_reg_addr", 32'(reg_addr_o), 32'd0);
        check32("reset_mem_addr", mem_addr_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        regs[5] = 32'd7;
        mem[0]  = 32'd5;
        pc_i    = 32'h20;
        ready_mode = 0;
        tick(1'b1);
        tick(1'b0);
        #2;
        check32("t1_first_valid", 32'(dump_valid_o), 32'd1);
        check32("t1_first_idx", 32'(dump_idx_o), 32'd0);
        finish_dump("t1");
        check32("t1_pc_word", got[0], 32'h20);
        check32("t1_x5_word", got[HDR + 5], 32'd7);
        check32("t1_mem0_word", got[HDR + 32], 32'd5);
`ifdef DUMP_PERF_CNT_EN
        check32("t1_last_idx", 32'(got_last_idx), 32'd43);
`else
        check32("t1_last_idx", 32'(got_last_idx), 32'd40);
`endif
        check32("t1_streams", 32'(n_streams), 32'd1);

        // 2: alternating ready; the compare process checks hold stability.
        randomize_cpu();
        pc_i = $urandom;
        ready_mode = 1;
        tick(1'b1);
        finish_dump("t2");
        check32("t2_streams", 32'(n_streams), 32'd2);
        check32("t2_hold_seen", 32'(n_holds > 0), 32'd1);

        // 4: requests mid-dump and on the last handshake are ignored.
        randomize_cpu();
        ready_mode = 0;
        streams_before = n_streams;
        tick(1'b1);
        repeat (5) tick(1'b0);
        tick(1'b1);
        for (int k = 0; k < 200; k++) begin
            tick(1'b0);
            #2;
            if (dump_idx_o == 6'(TOTAL - 2)) break;
        end
        tick(1'b1);
        repeat (6) tick(1'b0);
        #2;
        check32("t4_busy_after", 32'(busy_o), 32'd0);
        check32("t4_one_stream", 32'(n_streams - streams_before), 32'd1);

        // 5: asynchronous reset at idx 17 aborts the dump and clears counters.
        randomize_cpu();
        tick(1'b1, 1'b1);
        for (int k = 0; k < 200; k++) begin
            tick(1'b0, 1'b1);
            #2;
            if (dump_idx_o == 6'd17) break;
        end
        check32("t5_at_17", 32'(dump_idx_o), 32'd17);
        #1;
        rst_i = 1'b1;
        #1;
        check32("t5_valid", 32'(dump_valid_o), 32'd0);
        check32("t5_busy", 32'(busy_o), 32'd0);
        check32("t5_last", 32'(dump_last_o), 32'd0);
`ifdef DUMP_PERF_CNT_EN
        check32("t5_cyc_cnt", dut.cyc_cnt, 32'd0);
        check32("t5_stall_cnt", dut.stall_cnt, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        start_i = 1'b0;
        repeat (3) tick(1'b0);
        #2;
        check32("t5_no_words", 32'(dump_valid_o), 32'd0);

        // 3: 10 running cycles, 3 real stalls, 2 branch stalls, 2 flushes.
        pc_i = 32'h0000_0100;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1);
        finish_dump("t3");
        check32("t3_pc", got[0], 32'h0000_0100);
`ifdef DUMP_PERF_CNT_EN
        check32("t3_cycle", got[1], 32'd10);
        check32("t3_stall", got[2], 32'd3);
        check32("t3_flush", got[3], 32'd2);

        // 6: cycle counter saturates at all-ones.
        @(negedge clk);
        #3;
        force dut.u_cycle_cnt.cnt_q = 32'hFFFF_FFFE;
        m_cyc = 32'hFFFF_FFFE;
        #1;
        release dut.u_cycle_cnt.cnt_q;
        repeat (5) tick(1'b0, 1'b1);
        tick(1'b1);
        finish_dump("t6");
        check32("t6_cycle_sat", got[1], 32'hFFFF_FFFF);
`endif

        // Randomized traffic: random ready, strobes and CPU contents.
        ready_mode = 2;
        for (int d = 0; d < 6; d++) begin
            int gap;
            randomize_cpu();
            pc_i = $urandom;
            gap = $urandom_range(0, 10);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            finish_dump("rand");
        end
        repeat (2) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the sequence is bounded everywhere, this is a last resort.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
